// File: rtl/operand_reg_file.sv
// operand_reg_file: DEPTH x WIDTH register file feeding the ALU operand mux.
// One write-back port and two registered read ports. A read in the same cycle
// as a write to the same address returns the new write data (write-first).
// rd_valid marks the cycle in which a freshly read operand pair is presented.
// Every output is driven directly by a flop.
module operand_reg_file #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rd_valid
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit HARD_R0 = (ZERO_R0 != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             write_ok;

  // A write to r0 is discarded when r0 is hard-wired to zero.
  assign write_ok = we && !(HARD_R0 && (waddr == '0));

  // Resolve the value each read port would capture at the coming edge.
  always_comb begin
    // NOTE: defaults first so every path assigns next_a/next_b and no latch is inferred.
    next_a = mem[raddr_a];
    next_b = mem[raddr_b];
    if (we && (waddr == raddr_a)) next_a = wdata;
    if (we && (waddr == raddr_b)) next_b = wdata;
    if (HARD_R0 && (raddr_a == '0)) next_a = '0;
    if (HARD_R0 && (raddr_b == '0)) next_b = '0;
  end

  // Storage update and registered read ports; reset wins over write and read.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the array is cleared on reset because the first read after reset must return 0.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (write_ok) mem[waddr] <= wdata;
      if (rd_en) begin
        rdata_a <= next_a;
        rdata_b <= next_b;
      end
      rd_valid <= rd_en;
    end
  end

endmodule

// File: doc/operand_reg_file.md
# operand_reg_file

Synchronous register file that supplies the two operands feeding the ALU's 2:1 operand-select mux stage, and accepts the ALU result as write-back. It provides one write port and two independent registered read ports with write-first bypass, plus a read-valid strobe so downstream mux/ALU logic knows when operands are stable. It sits directly upstream of the operand mux and downstream of the ALU result path.

## Interface
Parameters:
- WIDTH, 8, data width of each register and of all data ports
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers (4 by default)
- ZERO_R0, 0, when 1 register 0 reads as all-zeros and ignores writes

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- we  input  1  write enable for the write-back port
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data (ALU result)
- rd_en  input  1  read request; samples raddr_a/raddr_b this cycle
- raddr_a  input  ADDR_W  read address, port A
- raddr_b  input  ADDR_W  read address, port B
- rdata_a  output  WIDTH  registered read data, port A (operand a of mux)
- rdata_b  output  WIDTH  registered read data, port B (operand b of mux)
- rd_valid  output  1  high the cycle after an accepted rd_en

## Operation
- Storage: DEPTH x WIDTH flops, mem[0..DEPTH-1].
- Reset (reset=1 at edge): every mem entry <= 0, rdata_a <= 0, rdata_b <= 0, rd_valid <= 0. Reset overrides we and rd_en in the same cycle; no write or read takes effect.
- Write: at edge with reset=0, we=1: mem[waddr] <= wdata. If ZERO_R0=1 and waddr=0, the write is dropped.
- Read: at edge with reset=0, rd_en=1: rdata_a <= value(raddr_a), rdata_b <= value(raddr_b), rd_valid <= 1.
- value(addr): if ZERO_R0=1 and addr=0 -> 0; else if we=1 and waddr=addr (same cycle) -> wdata (write-first bypass); else mem[addr].
- Both ports may read the same address; both get identical data, including bypassed data.
- rd_en=0: rdata_a/rdata_b hold their previous values; rd_valid <= 0.
- No address range checks: DEPTH is exactly 2**ADDR_W, so every address is valid.
- No handshake back-pressure: downstream must consume rdata while rd_valid=1 or rely on the hold behaviour.

## Timing
- Write latency: 1 cycle; data written at edge N is in mem from edge N onward.
- Read latency: 1 cycle; rd_en at edge N -> rdata/rd_valid valid after edge N, through cycle N+1.
- Back-to-back reads: rd_en high every cycle gives new data every cycle, with rd_valid held high.
- Read-after-write same cycle: bypass returns the new wdata, never the stale value.
- Write then read of same address on the next cycle: returns the new value from mem.
- Reset asserted mid-stream: at that edge rd_valid drops to 0, outputs go to 0 and all contents clear. The first read after deassertion returns 0 for every address.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive writes to all 4 regs, assert reset 1 cycle, then read each address -> rdata_a = rdata_b = 0x00, rd_valid = 0 during the reset cycle and 1 on the cycle after each read.
- Basic write/read: write 0x11/0x22/0x33/0x44 to r0..r3, then rd_en with raddr_a=1, raddr_b=3 -> next cycle rdata_a=0x22, rdata_b=0x44, rd_valid=1.
- Bypass: r2=0x33; in one cycle we=1, waddr=2, wdata=0xA5, rd_en=1, raddr_a=2, raddr_b=2 -> next cycle rdata_a = rdata_b = 0xA5.
- Hold and valid: after a read returning 0x22/0x44, drop rd_en for 3 cycles while writing other regs -> rdata unchanged, rd_valid = 0 for all 3 cycles.
- Reset priority: reset=1 together with we=1, waddr=1, wdata=0xFF and rd_en=1 -> after the edge r1=0x00, rd_valid=0. The following read of r1 returns 0x00.
- ZERO_R0=1 build: write 0x5A to r0, then read r0 on both ports -> 0x00. A same-cycle write/read to r0 also returns 0x00.
